md_sched: RTL and testbench

Multiply/divide sequencer for the pipelined MIPS core. It sits beside the E stage and accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO operations carrying the decoded rs/rt operand values. It models a fixed-latency iterative unit: a busy counter runs for the configured number of cycles, then HI/LO are committed. It also produces the D-stage stall request that keeps later MD-dependent instructions (mfhi/mflo/mult/...) from issuing while the unit is occupied.

---
 rtl/md_sched_if.sv | 18 +
 rtl/md_sched.sv | 132 +++++++++++++
 tb/tb_md_sched.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/md_sched_if.sv
// Operand, control and result bundle for the md_sched multiply/divide sequencer.
// master = E/D-stage side driving ops; slave = the sequencer itself.
interface md_sched_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        d_md_use;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        stall;

  modport master (output start, op, rs_val, rt_val, d_md_use,
                  input  busy, hi, lo, stall);
  modport slave  (input  start, op, rs_val, rt_val, d_md_use,
                  output busy, hi, lo, stall);
endinterface

// File: rtl/md_sched.sv
// Fixed-latency MD sequencer: computes the result at accept, holds it for the busy period, then commits HI/LO.
// Optional divide support is enabled by defining MD_SCHED_DIV_EN; without it DIV/DIVU are no-ops.
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic      clk,
  input logic      rst_n,
  md_sched_if.slave md
);
  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic {IDLE, RUN} state_t;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        we;
  } md_res_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  md_res_t            res, res_n;
  logic [31:0]        hi_q, hi_n, lo_q, lo_n;
  logic               last, accept, start_q;

  // Sign-extending both operands lets one 64x64 multiply (low half) serve signed and unsigned.
  logic        mul_sgn;
  logic [63:0] mul_a, mul_b, prod;
  always_comb begin
    mul_sgn = (md.op == OP_MULT);
    mul_a   = {{32{mul_sgn & md.rs_val[31]}}, md.rs_val};
    mul_b   = {{32{mul_sgn & md.rt_val[31]}}, md.rt_val};
    prod    = mul_a * mul_b;
  end

`ifdef MD_SCHED_DIV_EN
  // Magnitude divide then re-sign: avoids the INT_MIN/-1 overflow corner of a native signed divide.
  logic        div_sgn, neg_a, neg_b;
  logic [31:0] abs_a, abs_b, dvs, uq, ur, quo, rem;
  always_comb begin
    div_sgn = (md.op == OP_DIV);
    neg_a   = div_sgn & md.rs_val[31];
    neg_b   = div_sgn & md.rt_val[31];
    abs_a   = neg_a ? (~md.rs_val + 32'd1) : md.rs_val;
    abs_b   = neg_b ? (~md.rt_val + 32'd1) : md.rt_val;
    dvs     = (abs_b == 32'd0) ? 32'd1 : abs_b;
    uq      = abs_a / dvs;
    ur      = abs_a % dvs;
    quo     = (neg_a ^ neg_b) ? (~uq + 32'd1) : uq;
    rem     = neg_a ? (~ur + 32'd1) : ur;
  end
  assign start_q = md.start;
`else
  assign start_q = md.start & (md.op != OP_DIV) & (md.op != OP_DIVU);
`endif

  assign last   = (state == RUN) && (cnt == CNT_W'(1));
  // A new op may be taken on the same edge the current one retires.
  assign accept = md.start && ((state == IDLE) || last);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    res_n   = res;
    hi_n    = hi_q;
    lo_n    = lo_q;
    if (state == RUN) begin
      cnt_n = cnt - CNT_W'(1);
      if (last) begin
        state_n = IDLE;
        if (res.we) begin
          hi_n = res.hi;
          lo_n = res.lo;
        end
      end
    end
    // Accept after retire so an MTHI/MTLO on the retire edge wins over the older result.
    if (accept) begin
      case (md.op)
        OP_MULT, OP_MULTU: begin
          res_n.hi = prod[63:32];
          res_n.lo = prod[31:0];
          res_n.we = 1'b1;
          cnt_n    = CNT_W'(MULT_CYCLES);
          state_n  = RUN;
        end
`ifdef MD_SCHED_DIV_EN
        OP_DIV, OP_DIVU: begin
          res_n.hi = rem;
          res_n.lo = quo;
          res_n.we = (md.rt_val != 32'd0);
          cnt_n    = CNT_W'(DIV_CYCLES);
          state_n  = RUN;
        end
`endif
        OP_MTHI: hi_n = md.rs_val;
        OP_MTLO: lo_n = md.rs_val;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      res   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      res   <= res_n;
      hi_q  <= hi_n;
      lo_q  <= lo_n;
    end
  end

  assign md.busy  = (state == RUN);
  assign md.hi    = hi_q;
  assign md.lo    = lo_q;
  assign md.stall = md.d_md_use & (start_q | md.busy);
endmodule

// File: tb/tb_md_sched.sv
// Directed bench for md_sched: vector table of single ops plus hazard, back-to-back and reset sequences.
module tb_md_sched;
`ifdef MD_SCHED_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  localparam int MC = 5;
  localparam int DC = DIV_EN ? 10 : 0;

  logic clk = 1'b0;
  logic rst_n;
  md_sched_if bus();

  md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .rst_n(rst_n), .md(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
    bus.start  = 1'b1;
    bus.op     = op;
    bus.rs_val = rs;
    bus.rt_val = rt;
  endtask

  // Counts cycles busy stays high, bounded so a stuck unit cannot hang the run.
  task automatic count_busy(output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 50) begin
      n++;
      tick();
    end
  endtask

  initial begin
    int n;
    vecs[0]  = '{3'd0, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE, MC};
    vecs[1]  = '{3'd1, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, MC};
    vecs[2]  = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, MC};
    vecs[3]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MC};
    vecs[4]  = '{3'd2, 32'hFFFFFFF9, 32'd2,
                 DIV_EN ? 32'hFFFFFFFF : 32'hFFFFFFFE, DIV_EN ? 32'hFFFFFFFD : 32'h00000001, DC};
    vecs[5]  = '{3'd3, 32'd7,        32'd0,
                 DIV_EN ? 32'hFFFFFFFF : 32'hFFFFFFFE, DIV_EN ? 32'hFFFFFFFD : 32'h00000001, DC};
    vecs[6]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF,
                 DIV_EN ? 32'h00000000 : 32'hFFFFFFFE, DIV_EN ? 32'h80000000 : 32'h00000001, DC};
    vecs[7]  = '{3'd3, 32'd100,      32'd7,
                 DIV_EN ? 32'd2 : 32'hFFFFFFFE,        DIV_EN ? 32'd14 : 32'h00000001, DC};
    vecs[8]  = '{3'd2, 32'd7,        32'hFFFFFFFE,
                 DIV_EN ? 32'd1 : 32'hFFFFFFFE,        DIV_EN ? 32'hFFFFFFFD : 32'h00000001, DC};
    vecs[9]  = '{3'd4, 32'h12345678, 32'd0,
                 32'h12345678, DIV_EN ? 32'hFFFFFFFD : 32'h00000001, 0};
    vecs[10] = '{3'd5, 32'hCAFEF00D, 32'd0,        32'h12345678, 32'hCAFEF00D, 0};
    vecs[11] = '{3'd6, 32'hDEADBEEF, 32'd3,        32'h12345678, 32'hCAFEF00D, 0};
    vecs[12] = '{3'd0, 32'hFFFFFFF9, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFEB, MC};

    rst_n = 1'b0;
    bus.start = 1'b0; bus.op = 3'd7; bus.rs_val = '0; bus.rt_val = '0; bus.d_md_use = 1'b0;
    tick(); tick();
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_stall", {31'd0, bus.stall}, 32'd0);
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].rs, vecs[i].rt);
      tick();
      bus.start = 1'b0;
      count_busy(n);
      chk($sformatf("vec%0d_busy_cycles", i), n, vecs[i].cyc);
      chk($sformatf("vec%0d_hi", i), bus.hi, vecs[i].hi);
      chk($sformatf("vec%0d_lo", i), bus.lo, vecs[i].lo);
    end

    // Consecutive MTHI/MTLO: each visible one edge after acceptance.
    issue(3'd4, 32'hAAAA5555, 32'd0);
    tick();
    issue(3'd5, 32'h5555AAAA, 32'd0);
    chk("mthi_hi", bus.hi, 32'hAAAA5555);
    chk("mthi_busy", {31'd0, bus.busy}, 32'd0);
    tick();
    bus.start = 1'b0;
    chk("mtlo_lo", bus.lo, 32'h5555AAAA);
    chk("mtlo_hi", bus.hi, 32'hAAAA5555);
    chk("mtlo_busy", {31'd0, bus.busy}, 32'd0);

    // Hazard: stall through start cycle plus busy; mid-busy start ignored.
    bus.d_md_use = 1'b1;
    issue(3'd0, 32'd3, 32'd5);
    #1;
    chk("hz_stall_start", {31'd0, bus.stall}, 32'd1);
    tick();
    bus.start = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i == 3) issue(3'd0, 32'd100, 32'd100);
      #1;
      chk($sformatf("hz_stall_c%0d", i), {31'd0, bus.stall}, 32'd1);
      chk($sformatf("hz_busy_c%0d", i), {31'd0, bus.busy}, 32'd1);
      tick();
      bus.start = 1'b0;
    end
    chk("hz_stall_end", {31'd0, bus.stall}, 32'd0);
    chk("hz_busy_end", {31'd0, bus.busy}, 32'd0);
    chk("hz_hi", bus.hi, 32'd0);
    chk("hz_lo", bus.lo, 32'd15);
    bus.d_md_use = 1'b0;

    // Back-to-back: second MULT accepted on the edge the first retires.
    issue(3'd1, 32'd2, 32'd3);
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    issue(3'd1, 32'd4, 32'd5);
    tick();
    bus.start = 1'b0;
    chk("b2b_busy_cont", {31'd0, bus.busy}, 32'd1);
    chk("b2b_lo_first", bus.lo, 32'd6);
    count_busy(n);
    chk("b2b_busy_cycles", n, 5);
    chk("b2b_lo_second", bus.lo, 32'd20);
    chk("b2b_hi_second", bus.hi, 32'd0);

    // Reset mid-operation discards the pending result.
    issue(3'd4, 32'h11, 32'd0);
    tick();
    issue(3'd5, 32'h22, 32'd0);
    tick();
    issue(DIV_EN ? 3'd3 : 3'd1, 32'd100, 32'd7);
    tick();
    bus.start = 1'b0;
    repeat (3) tick();
    chk("mid_busy_before", {31'd0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_busy", {31'd0, bus.busy}, 32'd0);
    chk("mid_hi", bus.hi, 32'd0);
    chk("mid_lo", bus.lo, 32'd0);
    repeat (12) tick();
    chk("mid_hi_later", bus.hi, 32'd0);
    chk("mid_lo_later", bus.lo, 32'd0);
    chk("mid_busy_later", {31'd0, bus.busy}, 32'd0);

    // Reset after traffic, held two edges.
    issue(3'd4, 32'h77, 32'd0);
    tick();
    issue(3'd0, 32'd9, 32'd9);
    tick();
    bus.start = 1'b0;
    bus.d_md_use = 1'b1;
    rst_n = 1'b0;
    tick(); tick();
    chk("rst2_hi", bus.hi, 32'd0);
    chk("rst2_lo", bus.lo, 32'd0);
    chk("rst2_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst2_stall", {31'd0, bus.stall}, 32'd0);
    rst_n = 1'b1;
    bus.d_md_use = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
